ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example set-LEDs 0xED or reset 0xFF, over the same PS2_CLK/PS2_DATA pair that KeyboardDecoder receives on.
- It runs the full host-to-device sequence: request-to-send inhibit, 8 data bits LSB first, odd parity, stop bit, device ACK check, and a timeout abort.
- It sits beside KeyboardDecoder in top. Top builds each open-drain line as `low ? 1'b0 : 1'bz` and gates decoder input with busy.

Parameters:
- INHIBIT_CYCLES, 12000: clock-low hold time in clk cycles (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum cycles from clock release to ACK sample (20 ms).
- FILTER_LEN, 8: consecutive equal samples needed before a filtered line changes.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; the byte is accepted when tx_valid && tx_ready.
- ps2_clk_in  in  1  raw PS2_CLK pad value.
- ps2_data_in  in  1  raw PS2_DATA pad value.
- ps2_clk_low  out  1  1 = drive PS2_CLK low, 0 = release.
- ps2_data_low  out  1  1 = drive PS2_DATA low, 0 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: byte sent and ACK received low.
- ack_err  out  1  one-cycle pulse: ACK sampled high.
- timeout  out  1  one-cycle pulse: transfer aborted on timer expiry.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 except tx_ready, which is 1.
  - Both lines are released immediately, including when reset hits mid-frame.
- Input filtering:
  - Each raw line passes through a 2-flop synchroniser, then the FILTER_LEN filter.
  - A falling-edge strobe on the filtered clock is 1 cycle wide.
  - Latency from the pad to the strobe is 2+FILTER_LEN cycles.
- Accept: on tx_valid && tx_ready, latch tx_data and compute parity = ~^tx_data. tx_valid is ignored while busy.
- States and transitions:
  - IDLE -> INHIBIT on accept.
  - INHIBIT: ps2_clk_low=1, ps2_data_low=0 for exactly INHIBIT_CYCLES cycles -> REQ.
  - REQ: ps2_clk_low=1, ps2_data_low=1 (start bit) for 1 cycle -> SEND. The timeout counter clears here.
  - SEND: ps2_clk_low=0.
    - Falling edge k (k=1..8) sets ps2_data_low = ~data[k-1].
    - Falling edge 9 sets ps2_data_low = ~parity.
    - Falling edge 10 sets ps2_data_low=0 (stop bit) -> ACK.
  - ACK: on falling edge 11, sample the filtered data line.
    - Sampled 0 -> WAIT_IDLE with the ok flag set.
    - Sampled 1 -> WAIT_IDLE with ack_err pulsed.
  - WAIT_IDLE: when the filtered clock and data are both 1 -> IDLE. done pulses here if the ok flag is set.
- Data changes only in the cycle after a falling-edge strobe, never on rising edges.
- Timeout:
  - The counter runs in SEND and ACK.
  - On reaching TIMEOUT_CYCLES-1: release both lines, pulse timeout, go to IDLE directly.
  - done and ack_err are not asserted in that case.
- At most one of done, ack_err, timeout pulses per accepted byte.
- The bit counter is 4 bits and saturates; stray clock edges in WAIT_IDLE are ignored.
- If the device is mid-transmission when a byte is accepted, the host overrides: INHIBIT proceeds regardless.
- A new byte may be accepted in the cycle after returning to IDLE (back-to-back sends allowed).

Decomposition:
- Package ps2_pkg:
  - state encoding: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
  - command constants: CMD_SET_LEDS 8'hED, CMD_ECHO 8'hEE, CMD_RESET 8'hFF, RESP_ACK 8'hFA.
- Sub-module ps2_line_filter: synchroniser, FILTER_LEN glitch filter, falling-edge strobe. Instantiated twice (clock and data).
- The FSM, bit counter, inhibit/timeout counter and parity live in ps2_host_tx.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs low.
  - ps2_clk_low is high for exactly 12000 cycles.
  - Line bits after start: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; busy then falls.
- Send 0x01 and 0xFF.
  - Parity bits observed are 0 and 1 respectively.
  - tx_ready is 0 from accept until return to IDLE.
- Device model leaves data high at the 11th clock -> ack_err pulses once; no done.
- Device never clocks after release -> timeout pulses at TIMEOUT_CYCLES after REQ; both lines released; tx_ready=1.
- Assert rst=0 during bit 4 of a send.
  - ps2_clk_low and ps2_data_low go 0 in the same cycle (async).
  - The next send of 0xEE completes normally.
- Inject 3-cycle glitches on PS2_CLK during SEND -> no extra bits shifted; the transfer completes with done.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared state encoding, keyboard command codes and parity helper.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Purpose  : Two-flop synchroniser, run-length glitch filter and falling-edge strobe.
// Revision : 1.0
// ============================================================================
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_filt,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q, sync_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[0], line_in};
        filt_d = filt_q;
        cnt_d  = '0;
        // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
        end
    end

    assign line_filt = filt_q;
    assign fall      = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device command transmitter with ACK check and timeout.
// Revision : 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAXC + 1);

    logic clk_filt, clk_fall, data_filt, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk(clk), .rst(rst), .line_in(ps2_clk_in),
        .line_filt(clk_filt), .fall(clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk(clk), .rst(rst), .line_in(ps2_data_in),
        .line_filt(data_filt), .fall(data_fall_unused)
    );

    ps2_state_e    state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          parity_q, parity_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ok_q, ok_d;
    logic          clk_low_q, clk_low_d;
    logic          data_low_q, data_low_d;
    logic          tx_ready_q, tx_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        timer_d    = timer_q;
        ok_d       = ok_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        done_d     = 1'b0;
        ack_err_d  = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    data_d     = tx_data;
                    parity_d   = odd_parity(tx_data);
                    timer_d    = '0;
                    ok_d       = 1'b0;
                    clk_low_d  = 1'b1;
                    data_low_d = 1'b0;
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    data_low_d = 1'b1;
                    state_d    = REQ;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REQ: begin
                clk_low_d = 1'b0;
                timer_d   = '0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND, ACK: begin
                if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    clk_low_d  = 1'b0;
                    data_low_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (clk_fall) begin
                        if (bit_cnt_q != 4'hF) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                        if (state_q == SEND) begin
                            // Edges 1..8 carry data, 9 parity, 10 releases the line as stop bit.
                            if (bit_cnt_q < 4'd8) begin
                                data_low_d = ~data_q[bit_cnt_q[2:0]];
                            end else if (bit_cnt_q == 4'd8) begin
                                data_low_d = ~parity_q;
                            end else begin
                                data_low_d = 1'b0;
                                state_d    = ACK;
                            end
                        end else begin
                            ok_d      = ~data_filt;
                            ack_err_d = data_filt;
                            state_d   = WAIT_IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && data_filt) begin
                    done_d  = ok_q;
                    ok_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            ok_q       <= 1'b0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            timer_q    <= timer_d;
            ok_q       <= ok_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_ready     = tx_ready_q;
    assign busy         = busy_q;
    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
    assign done         = done_q;
    assign ack_err      = ack_err_q;
    assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Directed bench for ps2_host_tx with a behavioural keyboard on the wires.
// Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 120;
    localparam int TO  = 2000;
    localparam int FL  = 8;
    localparam int H   = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_low, ps2_data_low, busy, done, ack_err, timeout;
    logic       dev_clk_low, dev_data_low, dev_abort;
    logic       clk_line, data_line;
    int         dev_edges;

    int n_checks = 0, n_errors = 0;
    int n_done = 0, n_ack = 0, n_to = 0, n_viol = 0, n_inh = 0, n_req = 0, cyc = 0;

    assign clk_line  = !(ps2_clk_low || dev_clk_low);
    assign data_line = !(ps2_data_low || dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(clk_line), .ps2_data_in(data_line),
        .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low), .busy(busy),
        .done(done), .ack_err(ack_err), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done)    n_done++;
        if (ack_err) n_ack++;
        if (timeout) n_to++;
        if (tx_ready == busy) n_viol++;
        if (ps2_clk_low && !ps2_data_low) n_inh++;
        if (ps2_clk_low && ps2_data_low)  n_req++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dev_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Keyboard: waits for the start bit, clocks 10 bits sampling on rising edges, then ACKs.
    task automatic dev_frame(input bit ack_low, input bit glitch, output logic [10:0] bits);
        int n = 0;
        bits = '0;
        dev_edges = 0;
        while (!(busy && !ps2_clk_low && ps2_data_low) && n < 5000 && !dev_abort) begin
            @(negedge clk);
            n++;
        end
        chk("dev_start_seen", 32'(n < 5000), 32'd1);
        if (n >= 5000) return;
        dev_wait(30);
        bits[0] = data_line;
        for (int k = 1; k <= 10; k++) begin
            if (dev_abort) break;
            dev_clk_low = 1'b1;
            dev_edges++;
            dev_wait(H);
            dev_clk_low = 1'b0;
            dev_wait(H / 2);
            bits[k] = data_line;
            if (k == 10 && ack_low) dev_data_low = 1'b1;
            if (glitch && k >= 2 && k <= 9) begin
                dev_wait(5);
                dev_clk_low = 1'b1;
                dev_wait(3);
                dev_clk_low = 1'b0;
                dev_wait(H / 2 - 8);
            end else begin
                dev_wait(H / 2);
            end
        end
        if (!dev_abort) begin
            dev_clk_low = 1'b1;
            dev_edges++;
            dev_wait(H);
            dev_clk_low = 1'b0;
            dev_wait(H);
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_after_accept", 32'(tx_ready), 32'd0);
        // A second request while busy must not disturb the byte in flight.
        tx_data = ~b;
        dev_wait(20);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(n < 4000), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack_low, input bit glitch,
                             input bit exp_par, input int exp_done, input int exp_ack);
        logic [10:0] bits;
        int d0, a0, t0, v0, i0, r0;
        d0 = n_done; a0 = n_ack; t0 = n_to; v0 = n_viol; i0 = n_inh; r0 = n_req;
        fork
            send_byte(b);
            dev_frame(ack_low, glitch, bits);
        join
        wait_idle();
        dev_wait(2);
        $display("frame %s: byte %02h sampled %03h", tag, b, bits);
        chk({tag, "_start"},  32'(bits[0]), 32'd0);
        chk({tag, "_byte"},   32'(bits[8:1]), 32'(b));
        chk({tag, "_parity"}, 32'(bits[9]), 32'(exp_par));
        chk({tag, "_stop"},   32'(bits[10]), 32'd1);
        chk({tag, "_inhibit_cycles"}, 32'(n_inh - i0), 32'(INH));
        chk({tag, "_req_cycles"},     32'(n_req - r0), 32'd1);
        chk({tag, "_done"},    32'(n_done - d0), 32'(exp_done));
        chk({tag, "_ack_err"}, 32'(n_ack - a0), 32'(exp_ack));
        chk({tag, "_timeout"}, 32'(n_to - t0), 32'd0);
        chk({tag, "_ready_vs_busy"}, 32'(n_viol - v0), 32'd0);
        chk({tag, "_ready_end"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        logic [10:0] bits;
        int n, c0, t0;
        rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0; dev_abort = 1'b0;
        dev_wait(5);
        chk("rst_ready",    32'(tx_ready), 32'd1);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_clk_low",  32'(ps2_clk_low), 32'd0);
        chk("rst_data_low", 32'(ps2_data_low), 32'd0);
        chk("rst_pulses",   32'({done, ack_err, timeout}), 32'd0);
        rst = 1'b1;
        dev_wait(20);

        // 0xED: bits 1,0,1,1,0,1,1,1, six ones so parity 1.
        run_frame("leds", CMD_SET_LEDS, 1'b1, 1'b0, 1'b1, 1, 0);
        run_frame("x01",  8'h01,        1'b1, 1'b0, 1'b0, 1, 0);
        run_frame("xff",  CMD_RESET,    1'b1, 1'b0, 1'b1, 1, 0);
        run_frame("nack", CMD_SET_LEDS, 1'b0, 1'b0, 1'b1, 0, 1);

        // Silent device: abort exactly TO cycles after the clock is released.
        t0 = n_to;
        send_byte(CMD_ECHO);
        n = 0;
        while (!(busy && !ps2_clk_low) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        c0 = cyc;
        n = 0;
        while (!timeout && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency",  32'(cyc - c0), 32'(TO));
        chk("to_clk_rel",  32'(ps2_clk_low), 32'd0);
        chk("to_data_rel", 32'(ps2_data_low), 32'd0);
        chk("to_ready",    32'(tx_ready), 32'd1);
        dev_wait(3);
        chk("to_once",     32'(n_to - t0), 32'd1);
        chk("to_no_done",  32'(done), 32'd0);

        // Reset while inhibiting: the clock line is released without waiting for an edge.
        send_byte(8'h00);
        dev_wait(10);
        chk("inh_clk_held", 32'(ps2_clk_low), 32'd1);
        #2 rst = 1'b0;
        #1 chk("inh_rst_clk_rel", 32'(ps2_clk_low), 32'd0);
        chk("inh_rst_ready", 32'(tx_ready), 32'd1);
        @(negedge clk) rst = 1'b1;
        dev_wait(5);

        // Reset during bit 4 of 0x00 while the host is driving data low.
        fork
            send_byte(8'h00);
            dev_frame(1'b1, 1'b0, bits);
            begin
                n = 0;
                while (dev_edges < 4 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                dev_wait(15);
                chk("mid_data_driven", 32'(ps2_data_low), 32'd1);
                #2 rst = 1'b0;
                #1 chk("mid_rst_lines", 32'({ps2_clk_low, ps2_data_low}), 32'd0);
                chk("mid_rst_busy", 32'(busy), 32'd0);
                dev_abort = 1'b1;
            end
        join
        dev_abort = 1'b0;
        @(negedge clk) rst = 1'b1;
        dev_wait(20);

        run_frame("echo",   CMD_ECHO,     1'b1, 1'b0, 1'b1, 1, 0);
        run_frame("glitch", CMD_SET_LEDS, 1'b1, 1'b1, 1'b1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
